// File: rtl/ejtag_pctrace_ser.sv
`default_nettype none
// ============================================================================
// Module   : ejtag_pctrace_ser
// Purpose  : PC-trace serializer behind the EJTAG debug-clock generator.
//            Buffers PC trace entries from the core in a small FIFO. On each
//            EJT_DREN_R beat strobe it emits one TR_DATA nibble plus PCST code,
//            so the probe pins change once per EJT_DCLK period regardless of
//            the debug-clock divide ratio.
// Ports    : CLK, RESET (async, active-high)
//            EJT_DREN_R           beat strobe, one cycle wide
//            TRC_PUSH/PC/KIND     trace entry offered by the core
//            TRC_READY            FIFO not full (combinational)
//            TRC_OVF/TRC_OVF_CLR  sticky dropped-push flag and its clear
//            TR_PCST/TR_DATA      registered trace pins
//            TR_DVALID/TR_LAST    nibble valid / final nibble of an entry
//            TRC_BUSY             entry in flight or FIFO non-empty
// Config   : `define EJT_PCTRACE_COMPRESS_EN sends only the nibbles up to the
//            most-significant one that differs from the last-sent PC.
//            Left undefined, every entry is sent as PCW/4 nibbles.
// Revision : 1.0 - initial release
// ============================================================================
module ejtag_pctrace_ser #(
  parameter int DEPTH = 4,   // FIFO entries, power of 2, >= 2
  parameter int PCW   = 32   // PC width, multiple of 4
) (
  input  logic           CLK,
  input  logic           RESET,
  input  logic           EJT_DREN_R,
  input  logic           TRC_PUSH,
  input  logic [PCW-1:0] TRC_PC,
  input  logic [2:0]     TRC_KIND,
  output logic           TRC_READY,
  output logic           TRC_OVF,
  input  logic           TRC_OVF_CLR,
  output logic [2:0]     TR_PCST,
  output logic [3:0]     TR_DATA,
  output logic           TR_DVALID,
  output logic           TR_LAST,
  output logic           TRC_BUSY
);

  localparam int NIB = PCW / 4;
  localparam int BW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam int AW  = $clog2(DEPTH);

  localparam logic [AW:0]   FULL_CNT = DEPTH[AW:0];
  localparam logic [AW:0]   CNT_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [BW-1:0] BEAT_ONE = {{(BW-1){1'b0}}, 1'b1};
  localparam logic [BW-1:0] BEAT_MAX = BW'(NIB - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // --------------------------------------------------------------------------
  // Trace FIFO
  // --------------------------------------------------------------------------
  logic [PCW-1:0] fifo_pc   [DEPTH];
  logic [2:0]     fifo_kind [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [AW:0]    count;
  logic           full;
  logic           empty;
  logic           push_ok;
  logic           pop;
  logic [PCW-1:0] head_pc;
  logic [2:0]     head_kind;

  assign full      = (count == FULL_CNT);
  assign empty     = (count == '0);
  // Acceptance depends only on the count at the start of the cycle, so a
  // simultaneous pop never rescues a push into a full FIFO.
  assign push_ok   = TRC_PUSH && !full;
  assign head_pc   = fifo_pc[rd_ptr];
  assign head_kind = fifo_kind[rd_ptr];

  always_ff @(posedge CLK) begin
    if (push_ok) begin
      fifo_pc[wr_ptr]   <= TRC_PC;
      fifo_kind[wr_ptr] <= TRC_KIND;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      if (push_ok && !pop) begin
        count <= count + CNT_ONE;
      end else if (!push_ok && pop) begin
        count <= count - CNT_ONE;
      end
    end
  end

  // Sticky overflow; a dropped push wins over a clear in the same cycle.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      TRC_OVF <= 1'b0;
    end else if (TRC_PUSH && full) begin
      TRC_OVF <= 1'b1;
    end else if (TRC_OVF_CLR) begin
      TRC_OVF <= 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Index of the final beat for the entry at the FIFO head
  // --------------------------------------------------------------------------
  logic [PCW-1:0] last_pc;
  logic [BW-1:0]  head_last;

  always_comb begin
    head_last = BEAT_MAX;
`ifdef EJT_PCTRACE_COMPRESS_EN
    // Send nibbles up to and including the most-significant one that
    // changed; an unchanged PC still costs one beat.
    head_last = '0;
    for (int i = 0; i < NIB; i++) begin
      if (head_pc[4*i +: 4] != last_pc[4*i +: 4]) begin
        head_last = BW'(i);
      end
    end
`endif
  end

  // --------------------------------------------------------------------------
  // Serializer FSM
  // --------------------------------------------------------------------------
  state_t         state;
  state_t         state_nxt;
  logic [BW-1:0]  beat;
  logic [BW-1:0]  beat_nxt;
  logic [BW-1:0]  last_idx;
  logic [BW-1:0]  last_idx_nxt;
  logic [PCW-1:0] shreg;
  logic [PCW-1:0] shreg_nxt;
  logic [PCW-1:0] last_pc_nxt;
  logic [2:0]     pcst_nxt;
  logic [3:0]     data_nxt;
  logic           dvalid_nxt;
  logic           tlast_nxt;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state     <= IDLE;
      beat      <= '0;
      last_idx  <= '0;
      shreg     <= '0;
      last_pc   <= '0;
      TR_PCST   <= 3'b000;
      TR_DATA   <= 4'h0;
      TR_DVALID <= 1'b0;
      TR_LAST   <= 1'b0;
    end else begin
      state     <= state_nxt;
      beat      <= beat_nxt;
      last_idx  <= last_idx_nxt;
      shreg     <= shreg_nxt;
      last_pc   <= last_pc_nxt;
      TR_PCST   <= pcst_nxt;
      TR_DATA   <= data_nxt;
      TR_DVALID <= dvalid_nxt;
      TR_LAST   <= tlast_nxt;
    end
  end

  // Everything holds unless a strobe arrives; pins change only on strobes.
  always_comb begin
    state_nxt    = state;
    beat_nxt     = beat;
    last_idx_nxt = last_idx;
    shreg_nxt    = shreg;
    last_pc_nxt  = last_pc;
    pcst_nxt     = TR_PCST;
    data_nxt     = TR_DATA;
    dvalid_nxt   = TR_DVALID;
    tlast_nxt    = TR_LAST;
    pop          = 1'b0;

    if (EJT_DREN_R) begin
      unique case (state)
        IDLE: begin
          if (empty) begin
            pcst_nxt   = 3'b000;
            data_nxt   = 4'h0;
            dvalid_nxt = 1'b0;
            tlast_nxt  = 1'b0;
          end else begin
            // Beat 0 goes out straight from the FIFO head; the remaining
            // nibbles are kept pre-shifted so each later beat takes [3:0].
            pop          = 1'b1;
            pcst_nxt     = head_kind;
            data_nxt     = head_pc[3:0];
            dvalid_nxt   = 1'b1;
            tlast_nxt    = (head_last == '0);
            shreg_nxt    = head_pc >> 4;
            beat_nxt     = BEAT_ONE;
            last_idx_nxt = head_last;
            last_pc_nxt  = head_pc;
            state_nxt    = (head_last == '0) ? IDLE : SEND;
          end
        end
        SEND: begin
          pcst_nxt   = 3'b000;
          data_nxt   = shreg[3:0];
          dvalid_nxt = 1'b1;
          tlast_nxt  = (beat == last_idx);
          shreg_nxt  = shreg >> 4;
          beat_nxt   = beat + BEAT_ONE;
          if (beat == last_idx) begin
            state_nxt = IDLE;
          end
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

  assign TRC_READY = !full;
  assign TRC_BUSY  = (state != IDLE) || !empty;

endmodule
`default_nettype wire

// File: tb/tb_ejtag_pctrace_ser.sv
`default_nettype none
// ============================================================================
// Module   : tb_ejtag_pctrace_ser
// Purpose  : Self-checking bench for ejtag_pctrace_ser. A queue-based model
//            (FIFO of entries, list of pending beats per popped entry) is
//            compared against every DUT output on each falling edge; directed
//            scenarios also check hand-computed literal values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ejtag_pctrace_ser;

  localparam int DEPTH = 4;
  localparam int PCW   = 32;
  localparam int NIB   = PCW / 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        dren;
  logic        push;
  logic [31:0] pc;
  logic [2:0]  kind;
  logic        ovf_clr;
  logic        ready;
  logic        ovf;
  logic [2:0]  tr_pcst;
  logic [3:0]  tr_data;
  logic        tr_dvalid;
  logic        tr_last;
  logic        busy;

  always #5 clk = ~clk;

  ejtag_pctrace_ser #(.DEPTH(DEPTH), .PCW(PCW)) dut (
    .CLK         (clk),
    .RESET       (reset),
    .EJT_DREN_R  (dren),
    .TRC_PUSH    (push),
    .TRC_PC      (pc),
    .TRC_KIND    (kind),
    .TRC_READY   (ready),
    .TRC_OVF     (ovf),
    .TRC_OVF_CLR (ovf_clr),
    .TR_PCST     (tr_pcst),
    .TR_DATA     (tr_data),
    .TR_DVALID   (tr_dvalid),
    .TR_LAST     (tr_last),
    .TRC_BUSY    (busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Behavioural model
  // --------------------------------------------------------------------------
  typedef struct packed {logic [31:0] pc; logic [2:0] kind;} ent_t;
  typedef struct packed {logic [2:0] pcst; logic [3:0] data; logic last;} beat_t;

  ent_t        m_q[$];
  beat_t       m_beats[$];
  logic [2:0]  m_pcst;
  logic [3:0]  m_data;
  logic        m_dvalid;
  logic        m_last;
  logic        m_ovf;
  logic [31:0] m_last_pc;

  task automatic model_reset();
    m_q.delete();
    m_beats.delete();
    m_pcst    = 3'b000;
    m_data    = 4'h0;
    m_dvalid  = 1'b0;
    m_last    = 1'b0;
    m_ovf     = 1'b0;
    m_last_pc = 32'h0;
  endtask

  // Turn a popped entry into its list of pin beats.
  task automatic model_expand(input ent_t e);
    int    n;
    beat_t b;
    n = NIB;
`ifdef EJT_PCTRACE_COMPRESS_EN
    n = 1;
    for (int i = 0; i < NIB; i++) begin
      if (((e.pc >> (4*i)) & 32'hF) != ((m_last_pc >> (4*i)) & 32'hF)) n = i + 1;
    end
`endif
    m_last_pc = e.pc;
    for (int i = 0; i < n; i++) begin
      b.pcst = (i == 0) ? e.kind : 3'b000;
      b.data = 4'((e.pc >> (4*i)) & 32'hF);
      b.last = (i == n - 1);
      m_beats.push_back(b);
    end
  endtask

  task automatic model_step();
    int    sz0;
    ent_t  e;
    beat_t b;
    sz0 = m_q.size();
    if (dren) begin
      if (m_beats.size() == 0 && m_q.size() > 0) begin
        e = m_q.pop_front();
        model_expand(e);
      end
      if (m_beats.size() > 0) begin
        b        = m_beats.pop_front();
        m_pcst   = b.pcst;
        m_data   = b.data;
        m_dvalid = 1'b1;
        m_last   = b.last;
      end else begin
        m_pcst   = 3'b000;
        m_data   = 4'h0;
        m_dvalid = 1'b0;
        m_last   = 1'b0;
      end
    end
    if (push && sz0 < DEPTH) begin
      e.pc   = pc;
      e.kind = kind;
      m_q.push_back(e);
    end else if (push) begin
      m_ovf = 1'b1;
    end else if (ovf_clr) begin
      m_ovf = 1'b0;
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge reset);
      if (reset) model_reset();
      else       model_step();
    end
  end

  // Compare every DUT output against the model on each falling edge.
  initial begin
    forever begin
      @(negedge clk);
      chk("m_pcst",   tr_pcst,   m_pcst);
      chk("m_data",   tr_data,   m_data);
      chk("m_dvalid", tr_dvalid, m_dvalid);
      chk("m_last",   tr_last,   m_last);
      chk("m_ovf",    ovf,       m_ovf);
      chk("m_ready",  ready,     (m_q.size() < DEPTH));
      chk("m_busy",   busy,      (m_beats.size() > 0 || m_q.size() > 0));
    end
  end

  // --------------------------------------------------------------------------
  // Directed stimulus
  // --------------------------------------------------------------------------
  typedef struct packed {logic [2:0] pcst; logic [3:0] data; logic dvalid; logic last;} obs_t;
  obs_t obs_q[$];
  int   t2_data [8];

  // One clock cycle of inputs; records the pins after any strobe.
  task automatic cyc(input logic s, input logic p, input logic [31:0] a,
                     input logic [2:0] k, input logic c);
    obs_t o;
    dren = s; push = p; pc = a; kind = k; ovf_clr = c;
    @(posedge clk); #2;
    dren = 1'b0; push = 1'b0; ovf_clr = 1'b0;
    if (s) begin
      o.pcst = tr_pcst; o.data = tr_data; o.dvalid = tr_dvalid; o.last = tr_last;
      obs_q.push_back(o);
    end
  endtask

  task automatic strobes(input int n);
    for (int i = 0; i < n; i++) begin
      cyc(1'b1, 1'b0, 32'h0, 3'b0, 1'b0);
      cyc(1'b0, 1'b0, 32'h0, 3'b0, 1'b0);
    end
  endtask

  initial begin
    int nh;
    reset = 1'b1; dren = 1'b0; push = 1'b0; pc = '0; kind = '0; ovf_clr = 1'b0;
    t2_data = '{4, 3, 2, 1, 0, 0, 0, 8};
    repeat (3) @(posedge clk);
    #2;
    chk("rst_pcst",   tr_pcst,   0);
    chk("rst_data",   tr_data,   0);
    chk("rst_dvalid", tr_dvalid, 0);
    chk("rst_last",   tr_last,   0);
    chk("rst_ready",  ready,     1);
    chk("rst_busy",   busy,      0);
    chk("rst_ovf",    ovf,       0);
    reset = 1'b0;

    // Idle strobes
    obs_q.delete();
    strobes(10);
    chk("t1_count", obs_q.size(), 10);
    foreach (obs_q[i]) begin
      chk("t1_pcst",   obs_q[i].pcst,   0);
      chk("t1_dvalid", obs_q[i].dvalid, 0);
    end
    chk("t1_busy", busy, 0);

    // Full 8-beat entry, strobe every third cycle
    cyc(1'b0, 1'b1, 32'h8000_1234, 3'b001, 1'b0);
    obs_q.delete();
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 1'b0, 32'h0, 3'b0, 1'b0);
      cyc(1'b0, 1'b0, 32'h0, 3'b0, 1'b0);
      cyc(1'b0, 1'b0, 32'h0, 3'b0, 1'b0);
    end
    chk("t2_count", obs_q.size(), 8);
    for (int i = 0; i < 8 && i < obs_q.size(); i++) begin
      chk("t2_data",   obs_q[i].data,   t2_data[i]);
      chk("t2_pcst",   obs_q[i].pcst,   (i == 0) ? 1 : 0);
      chk("t2_last",   obs_q[i].last,   (i == 7) ? 1 : 0);
      chk("t2_dvalid", obs_q[i].dvalid, 1);
    end
    chk("t2_busy", busy, 0);

    // Fill past full, overflow, clear
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 1'b1, 32'h1000_000A + 32'(i), 3'(i + 1), 1'b0);
      if (i == 3) chk("t3_ready_full", ready, 0);
      if (i == 2) chk("t3_ready_3", ready, 1);
    end
    chk("t3_ovf_set", ovf, 1);
    cyc(1'b0, 1'b0, 32'h0, 3'b0, 1'b0);
    cyc(1'b0, 1'b0, 32'h0, 3'b0, 1'b0);
    chk("t3_ovf_hold", ovf, 1);
    cyc(1'b0, 1'b0, 32'h0, 3'b0, 1'b1);
    chk("t3_ovf_clr", ovf, 0);

    // Dropped push and clear in the same cycle: set wins
    cyc(1'b0, 1'b1, 32'h1000_000F, 3'b110, 1'b1);
    chk("t4_ovf_prio", ovf, 1);
    cyc(1'b0, 1'b0, 32'h0, 3'b0, 1'b1);
    chk("t4_ovf_clr", ovf, 0);

    // Drain and verify FIFO order via the beat-0 PCST/nibble of each entry
    obs_q.delete();
    strobes(40);
    nh = 0;
    foreach (obs_q[i]) begin
      if (obs_q[i].pcst != 3'b000) begin
        if (nh < 4) begin
          chk("t3_order_kind", obs_q[i].pcst, nh + 1);
          chk("t3_order_data", obs_q[i].data, 10 + nh);
        end
        nh++;
      end
    end
    chk("t3_order_count", nh, 4);
    chk("t3_busy", busy, 0);

`ifdef EJT_PCTRACE_COMPRESS_EN
    cyc(1'b0, 1'b1, 32'h8000_1234, 3'b001, 1'b0);
    strobes(10);
    obs_q.delete();
    cyc(1'b0, 1'b1, 32'h8000_1238, 3'b010, 1'b0);
    strobes(3);
    chk("t5_b0_data",   obs_q[0].data,   8);
    chk("t5_b0_last",   obs_q[0].last,   1);
    chk("t5_b0_pcst",   obs_q[0].pcst,   2);
    chk("t5_b1_dvalid", obs_q[1].dvalid, 0);
    obs_q.delete();
    cyc(1'b0, 1'b1, 32'h8000_1300, 3'b001, 1'b0);
    strobes(4);
    chk("t5_c0_data",   obs_q[0].data,   0);
    chk("t5_c1_data",   obs_q[1].data,   0);
    chk("t5_c2_data",   obs_q[2].data,   3);
    chk("t5_c1_last",   obs_q[1].last,   0);
    chk("t5_c2_last",   obs_q[2].last,   1);
    chk("t5_c3_dvalid", obs_q[3].dvalid, 0);
`endif

    // Reset mid-entry
    cyc(1'b0, 1'b1, 32'hCAFE_F00D, 3'b011, 1'b0);
    obs_q.delete();
    strobes(4);
    chk("t6_beat3_data", obs_q[3].data, 4'hF);
    chk("t6_busy_mid",   busy,          1);
    reset = 1'b1;
    #1;
    chk("t6_rst_pcst",   tr_pcst,   0);
    chk("t6_rst_data",   tr_data,   0);
    chk("t6_rst_dvalid", tr_dvalid, 0);
    chk("t6_rst_last",   tr_last,   0);
    chk("t6_rst_busy",   busy,      0);
    chk("t6_rst_ready",  ready,     1);
    @(posedge clk); #2;
    reset = 1'b0;
    cyc(1'b0, 1'b1, 32'h0000_00A5, 3'b010, 1'b0);
    obs_q.delete();
    strobes(3);
    chk("t6_new_pcst",   obs_q[0].pcst,   2);
    chk("t6_new_data0",  obs_q[0].data,   5);
    chk("t6_new_dvalid", obs_q[0].dvalid, 1);
    chk("t6_new_data1",  obs_q[1].data,   4'hA);
    strobes(10);
    chk("t6_busy_end", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
